// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM column-slice access controller.
// Contents:
//   state_t   - controller phase encoding
//   DEF_*     - default geometry and phase timing
//   MAX_*     - largest geometry the one-hot helper supports
//   onehot()  - row index to one-hot word-line vector
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        GAP   = 3'd2,
        WRITE = 3'd3,
        RDWL  = 3'd4,
        SENSE = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int DEF_COLS    = 8;
    localparam int DEF_ROWS    = 16;
    localparam int DEF_PRE_CYC = 2;
    localparam int DEF_WL_CYC  = 3;
    localparam int DEF_SA_CYC  = 1;

    localparam int MAX_AW   = 12;
    localparam int MAX_ROWS = 4096;

    // Callers keep the low ROWS bits of the result.
    function automatic logic [MAX_ROWS-1:0] onehot(input logic [MAX_AW-1:0] idx);
        return {{(MAX_ROWS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between a digital requester and sram_access_ctrl.
// Signals:
//   req_valid/req_ready  - request handshake (accept when both high)
//   req_we/addr/wdata    - access descriptor
//   rsp_valid/rsp_rdata  - read response pulse and held read data
//   wr_done              - write completion pulse
// Modports: master = requester, slave = controller.
interface sram_access_ctrl_if #(
    parameter int COLS   = 8,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [COLS-1:0]   req_wdata;
    logic              rsp_valid;
    logic [COLS-1:0]   rsp_rdata;
    logic              wr_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, wr_done
    );
endinterface

// File: rtl/sram_access_ctrl_row_decoder.sv
// Registered row decoder: latched row address -> one-hot word-line select.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   en         - a row phase is active; when low the word lines are all zero
//   addr       - row address
//   wl_sel     - registered one-hot (or all-zero) word-line select
module sram_row_decoder
    import sram_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   wl_sel
);
    logic [MAX_ROWS-1:0] oh_unused_s;
    logic [ROWS-1:0]     wl_sel_d;
    logic [ROWS-1:0]     wl_sel_q;

    // Decode the row only while a row phase is enabled.
    always_comb begin
        oh_unused_s = onehot(MAX_AW'(addr));
        if (en) begin
            wl_sel_d = oh_unused_s[ROWS-1:0];
        end else begin
            wl_sel_d = {ROWS{1'b0}};
        end
    end

    // Word-line select register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_sel_q <= {ROWS{1'b0}};
        end else begin
            wl_sel_q <= wl_sel_d;
        end
    end

    assign wl_sel = wl_sel_q;
endmodule

// File: rtl/sram_access_ctrl.sv
// Sequencer for one SRAM column slice: precharge, gap, word line with write
// drive or sensing, then a one-cycle response. One access in flight at a time.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - request/response bus (slave side)
//   pre_en     - bitline precharge enable
//   wl_sel     - one-hot word-line select, zero when no row is active
//   wd_en      - write driver enable
//   wd_data    - write driver data
//   sa_en      - sense amplifier enable
//   sa_out     - sense amplifier result
// Every enable is a flop of the previous cycle's phase, so phase boundaries
// are clean and nothing combinational reaches the array.
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int ADDR_W  = $clog2(ROWS),
    parameter int PRE_CYC = DEF_PRE_CYC,
    parameter int WL_CYC  = DEF_WL_CYC,
    parameter int SA_CYC  = DEF_SA_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_access_ctrl_if.slave     bus,
    output logic                  pre_en,
    output logic [ROWS-1:0]       wl_sel,
    output logic                  wd_en,
    output logic [COLS-1:0]       wd_data,
    output logic                  sa_en,
    input  logic [COLS-1:0]       sa_out
);
    if ((ROWS < 2) || ((ROWS & (ROWS - 1)) != 0) || (ROWS > (1 << MAX_AW))) begin : g_bad_rows
        $error("sram_access_ctrl: ROWS must be a power of two between 2 and 4096");
    end
    if ((PRE_CYC < 1) || (WL_CYC < 1) || (SA_CYC < 1)) begin : g_bad_timing
        $error("sram_access_ctrl: phase lengths must be at least 1 cycle");
    end

    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? ((PRE_CYC > SA_CYC) ? PRE_CYC : SA_CYC)
                                                : ((WL_CYC > SA_CYC) ? WL_CYC : SA_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL_CYC - 1);
    localparam logic [CNT_W-1:0] SA_LD  = CNT_W'(SA_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_Z  = {CNT_W{1'b0}};

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              we_d, we_q;
    logic [COLS-1:0]   wdata_d, wdata_q;
    logic              req_ready_d, req_ready_q;
    logic              pre_en_d, pre_en_q;
    logic              wd_en_d, wd_en_q;
    logic [COLS-1:0]   wd_data_d, wd_data_q;
    logic              sa_en_d, sa_en_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic [COLS-1:0]   rsp_rdata_d, rsp_rdata_q;
    logic              wr_done_d, wr_done_q;
    logic              row_en_s;
    logic              accept_s;

    // Phase sequencing; the counter counts down from length-1 and reloads on entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        accept_s = bus.req_valid && req_ready_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = PRECH;
                    cnt_d   = PRE_LD;
                    addr_d  = bus.req_addr;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            PRECH: begin
                if (cnt_q == CNT_Z) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                cnt_d = WL_LD;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RDWL;
                end
            end
            WRITE: begin
                if (cnt_q == CNT_Z) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RDWL: begin
                if (cnt_q == CNT_Z) begin
                    state_d = SENSE;
                    cnt_d   = SA_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SENSE: begin
                if (cnt_q == CNT_Z) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = CNT_Z;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_Z;
            end
        endcase
    end

    // Output next-values derived from the current phase; sa_out is captured
    // in DONE, i.e. during the cycle in which the last sa_en is driven.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        pre_en_d    = (state_q == PRECH);
        wd_en_d     = (state_q == WRITE);
        sa_en_d     = (state_q == SENSE);
        row_en_s    = (state_q == WRITE) || (state_q == RDWL) || (state_q == SENSE);
        wr_done_d   = (state_q == DONE) && we_q;
        rsp_valid_d = (state_q == DONE) && !we_q;
        if (state_q == WRITE) begin
            wd_data_d = wdata_q;
        end else begin
            wd_data_d = {COLS{1'b0}};
        end
        if ((state_q == DONE) && !we_q) begin
            rsp_rdata_d = sa_out;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // State, counter, latched request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_Z;
            addr_q      <= {ADDR_W{1'b0}};
            we_q        <= 1'b0;
            wdata_q     <= {COLS{1'b0}};
            req_ready_q <= 1'b1;
            pre_en_q    <= 1'b0;
            wd_en_q     <= 1'b0;
            wd_data_q   <= {COLS{1'b0}};
            sa_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {COLS{1'b0}};
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            pre_en_q    <= pre_en_d;
            wd_en_q     <= wd_en_d;
            wd_data_q   <= wd_data_d;
            sa_en_q     <= sa_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_done_q   <= wr_done_d;
        end
    end

    sram_row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (row_en_s),
        .addr   (addr_q),
        .wl_sel (wl_sel)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.wr_done   = wr_done_q;
    assign pre_en        = pre_en_q;
    assign wd_en         = wd_en_q;
    assign wd_data       = wd_data_q;
    assign sa_en         = sa_en_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (COLS=8, ROWS=16, PRE=2, WL=3, SA=1).
// Expected waveforms are derived by cycle index j, counted in rising edges
// after the accept edge (j=0 is sampled just after the accept edge).
module tb_sram_access_ctrl;
    localparam int PRE = 2;
    localparam int WL  = 3;
    localparam int SA  = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] wl_sel;
    logic        pre_en, wd_en, sa_en;
    logic [7:0]  wd_data, sa_out;
    logic [7:0]  last_rd;
    int          n_cmp;
    int          n_fail;

    sram_access_ctrl_if #(.COLS(8), .ADDR_W(4)) bus ();

    sram_access_ctrl #(
        .COLS(8), .ROWS(16), .ADDR_W(4), .PRE_CYC(PRE), .WL_CYC(WL), .SA_CYC(SA)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pre_en  (pre_en),
        .wl_sel  (wl_sel),
        .wd_en   (wd_en),
        .wd_data (wd_data),
        .sa_en   (sa_en),
        .sa_out  (sa_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s j=%0d observed=%h expected=%h", tag, j, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mutual-exclusion invariants, sampled on every falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("inv_pre_excl", 0, {31'd0, pre_en && ((wl_sel != 16'h0000) || wd_en || sa_en)}, 32'd0);
            chk("inv_wd_sa", 0, {31'd0, wd_en && sa_en}, 32'd0);
            chk("inv_wl_onehot0", 0, {31'd0, $onehot0(wl_sel)}, 32'd1);
        end
    end

    // One access; hold keeps req_valid high afterwards, poke alters req_* in
    // WRITE, abort_j >= 0 asserts reset at that cycle instead of completing.
    task automatic access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                          input logic [7:0] sa, input bit hold, input bit poke, input int abort_j);
        int          lat;
        int          guard;
        logic [15:0] oh;
        bit          wl_on;
        oh  = 16'h0001 << addr;
        lat = we ? (PRE + 2 + WL) : (PRE + 2 + WL + SA);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        sa_out        = ~sa;
        guard         = 0;
        while ((bus.req_ready !== 1'b1) && (guard < 50)) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            chk("ready_timeout", guard, 32'd0, 32'd1);
        end
        tick();
        for (int j = 0; j <= lat; j++) begin
            if ((j == 0) && !hold) bus.req_valid = 1'b0;
            wl_on = we ? ((j >= PRE + 2) && (j <= PRE + 1 + WL))
                       : ((j >= PRE + 2) && (j <= PRE + 1 + WL + SA));
            chk("req_ready", j, {31'd0, bus.req_ready}, {31'd0, j == lat});
            chk("pre_en", j, {31'd0, pre_en}, {31'd0, (j >= 1) && (j <= PRE)});
            chk("wl_sel", j, {16'd0, wl_sel}, wl_on ? {16'd0, oh} : 32'd0);
            chk("wd_en", j, {31'd0, wd_en}, {31'd0, we && wl_on});
            chk("wd_data", j, {24'd0, wd_data}, (we && wl_on) ? {24'd0, wd} : 32'd0);
            chk("sa_en", j, {31'd0, sa_en}, {31'd0, !we && (j >= PRE + 2 + WL) && (j <= PRE + 1 + WL + SA)});
            chk("wr_done", j, {31'd0, bus.wr_done}, {31'd0, we && (j == lat)});
            chk("rsp_valid", j, {31'd0, bus.rsp_valid}, {31'd0, !we && (j == lat)});
            chk("rsp_rdata", j, {24'd0, bus.rsp_rdata},
                (!we && (j == lat)) ? {24'd0, sa} : {24'd0, last_rd});
            if (j == abort_j) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pre_en", j, {31'd0, pre_en}, 32'd0);
                chk("rst_wl_sel", j, {16'd0, wl_sel}, 32'd0);
                chk("rst_wd_sa", j, {30'd0, wd_en, sa_en}, 32'd0);
                chk("rst_ready", j, {31'd0, bus.req_ready}, 32'd1);
                tick();
                rst_n = 1'b1;
                last_rd = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    chk("post_rst_rsp", k, {30'd0, bus.rsp_valid, bus.wr_done}, 32'd0);
                    chk("post_rst_idle", k, {29'd0, pre_en, wd_en, sa_en}, 32'd0);
                    chk("post_rst_rdata", k, {24'd0, bus.rsp_rdata}, 32'd0);
                    tick();
                end
                return;
            end
            if (poke && (j == PRE + 2)) begin
                bus.req_addr  = 4'd3;
                bus.req_wdata = 8'h00;
            end
            sa_out = (!we && (j == lat - 1)) ? sa : ~sa;
            if (j < lat) tick();
        end
        if (!we) last_rd = sa;
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        last_rd       = 8'h00;
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 8'h00;
        sa_out        = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_ready", 0, {31'd0, bus.req_ready}, 32'd1);
        chk("reset_wl_sel", 0, {16'd0, wl_sel}, 32'd0);
        chk("reset_enables", 0, {29'd0, pre_en, wd_en, sa_en}, 32'd0);
        chk("reset_rdata", 0, {24'd0, bus.rsp_rdata}, 32'd0);
        chk("reset_pulses", 0, {30'd0, bus.rsp_valid, bus.wr_done}, 32'd0);
        chk("reset_wd_data", 0, {24'd0, wd_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 1, {31'd0, bus.req_ready}, 32'd1);
        chk("idle_enables", 1, {29'd0, pre_en, wd_en, sa_en}, 32'd0);

        // Write 5/A5 with req_* changed mid-WRITE; then read 15 returning 3C.
        access(1'b1, 4'd5, 8'hA5, 8'h00, 1'b0, 1'b1, -1);
        tick();
        access(1'b0, 4'd15, 8'h00, 8'h3C, 1'b0, 1'b0, -1);
        tick();

        // Back-to-back with req_valid held: two writes then one read.
        access(1'b1, 4'd2, 8'h11, 8'h00, 1'b1, 1'b0, -1);
        access(1'b1, 4'd10, 8'hF0, 8'h00, 1'b1, 1'b0, -1);
        access(1'b0, 4'd5, 8'h00, 8'hC3, 1'b0, 1'b0, -1);
        tick();

        // Reset during RDWL, then a clean read of row 0.
        access(1'b0, 4'd9, 8'h00, 8'h77, 1'b0, 1'b0, PRE + 3);
        access(1'b0, 4'd0, 8'h00, 8'h5A, 1'b0, 1'b0, -1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
